// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter, fixed or round-robin.
// Holds each grant with a valid/ack handshake and counts acks.
module prio_encoder_arb #(
    parameter int N  = 8,
    parameter int W  = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i,
    input  logic          mode,
    input  logic          ack,
    output logic [W-1:0]  y,
    output logic [N-1:0]  grant,
    output logic          valid,
    output logic [CW-1:0] gcnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_nxt;
    logic [W-1:0] start;
    logic [W-1:0] win;
    logic         win_ok;
    logic         rearb;
    logic [W:0]   yinc;
    logic [W:0]   sum;
    logic [N-1:0] rot;

    assign rearb = (state == GRANT) && ack;

    // Successor of the current grant, wrapping N-1 back to 0
    always_comb begin
        yinc = {1'b0, y} + (W+1)'(1);
        if (yinc >= (W+1)'(N))
            ptr_nxt = '0;
        else
            ptr_nxt = yinc[W-1:0];
    end

    // Search origin: 0 when fixed, else the pointer as it stands after this edge
    always_comb begin
        start = '0;
        if (mode)
            start = rearb ? ptr_nxt : ptr;
    end

    // Rotate requests so the origin sits at bit 0, take the lowest set bit
    always_comb begin
        rot    = N'({i, i} >> start);
        win_ok = 1'b0;
        sum    = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (rot[k]) begin
                win_ok = 1'b1;
                sum    = {1'b0, start} + (W+1)'(k);
            end
        end
        if (sum >= (W+1)'(N))
            sum = sum - (W+1)'(N);
        win = sum[W-1:0];
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            grant <= '0;
            valid <= 1'b0;
            gcnt  <= '0;
            ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_ok) begin
                        y     <= win;
                        grant <= {{(N-1){1'b0}}, 1'b1} << win;
                        valid <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        gcnt <= gcnt + CW'(1);
                        ptr  <= ptr_nxt;
                        if (win_ok) begin
                            y     <= win;
                            grant <= {{(N-1){1'b0}}, 1'b1} << win;
                        end else begin
                            grant <= '0;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Scoreboard bench for prio_encoder_arb: an N=8 and an N=5/CW=2
// instance driven in parallel against a transaction-level model.
module tb_prio_encoder_arb;

    typedef struct {
        bit v;
        int y;
        int g;
        int c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;
    logic       mode = 1'b0;
    logic       ack = 1'b0;

    logic [2:0] y0;
    logic [7:0] g0;
    logic       v0;
    logic [7:0] c0;
    logic [2:0] y1;
    logic [4:0] g1;
    logic       v1;
    logic [1:0] c1;

    int vectors = 0;
    int miscompares = 0;

    bit mv[2];
    int my[2];
    int mptr[2];
    int mcnt[2];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    prio_encoder_arb #(.N(8), .W(3), .CW(8)) dut8 (
        .clk(clk), .rst(rst), .i(req8), .mode(mode), .ack(ack),
        .y(y0), .grant(g0), .valid(v0), .gcnt(c0)
    );

    prio_encoder_arb #(.N(5), .W(3), .CW(2)) dut5 (
        .clk(clk), .rst(rst), .i(req5), .mode(mode), .ack(ack),
        .y(y1), .grant(g1), .valid(v1), .gcnt(c1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 0;
            my[d] = 0;
            mptr[d] = 0;
            mcnt[d] = 0;
        end
    endtask

    // One clock of the arbiter, described at transaction level
    task automatic model_step(input int d, input logic [7:0] r, input logic md, input logic ak);
        int n;
        int cmax;
        int st;
        int idx;
        bit arb;
        n = (d == 1) ? 5 : 8;
        cmax = (d == 1) ? 4 : 256;
        arb = 0;
        if (!mv[d]) begin
            arb = 1;
        end else if (ak) begin
            mcnt[d] = (mcnt[d] + 1) % cmax;
            mptr[d] = (my[d] + 1) % n;
            arb = 1;
        end
        if (arb) begin
            mv[d] = 0;
            st = md ? mptr[d] : 0;
            for (int k = 0; k < n; k++) begin
                idx = (st + k) % n;
                if (!mv[d] && r[idx]) begin
                    mv[d] = 1;
                    my[d] = idx;
                end
            end
        end
    endtask

    function automatic exp_t mk(input int d);
        exp_t e;
        e.v = mv[d];
        e.y = my[d];
        e.g = mv[d] ? (1 << my[d]) : 0;
        e.c = mcnt[d];
        return e;
    endfunction

    task automatic apply(input logic [7:0] r8, input logic [4:0] r5, input logic md, input logic ak);
        @(negedge clk);
        req8 = r8;
        req5 = r5;
        mode = md;
        ack = ak;
        model_step(0, r8, md, ak);
        model_step(1, {3'b000, r5}, md, ak);
        q0.push_back(mk(0));
        q1.push_back(mk(1));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_run(input int cycles);
        logic [7:0] r8;
        logic [4:0] r5;
        for (int c = 0; c < cycles; c++) begin
            r8 = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
            r5 = ($urandom % 5 == 0) ? 5'h00 : 5'($urandom);
            apply(r8, r5, 1'($urandom % 3 != 0), 1'($urandom % 5 < 3));
        end
    endtask

    // Monitor: pop and compare after every active edge
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check("n8_valid", int'(v0), int'(e0.v));
                check("n8_grant", int'(g0), e0.g);
                check("n8_gcnt", int'(c0), e0.c);
                if (e0.v)
                    check("n8_y", int'(y0), e0.y);
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("n5_valid", int'(v1), int'(e1.v));
                check("n5_grant", int'(g1), e1.g);
                check("n5_gcnt", int'(c1), e1.c);
                if (e1.v)
                    check("n5_y", int'(y1), e1.y);
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check("rst_valid", int'(v0), 0);
        check("rst_grant", int'(g0), 0);
        check("rst_gcnt", int'(c0), 0);
        check("rst_y", int'(y0), 0);
        check("rst_valid5", int'(v1), 0);
        @(negedge clk);
        rst = 1'b0;

        // round-robin rotation with all requesters up
        for (int k = 0; k < 10; k++)
            apply(8'hFF, 5'h1F, 1'b1, 1'b1);
        settle();
        check("rr_y8", int'(y0), 1);
        check("rr_gcnt8", int'(c0), 9);
        check("rr_y5", int'(y1), 4);
        check("rr_gcnt5_wrap", int'(c1), 1);

        // fixed priority
        for (int k = 0; k < 4; k++)
            apply(8'hA8, 5'h0C, 1'b0, 1'b1);
        settle();
        check("fix_y3", int'(y0), 3);
        apply(8'h80, 5'h10, 1'b0, 1'b1);
        settle();
        check("fix_y7", int'(y0), 7);
        check("fix_g80", int'(g0), 8'h80);

        // drain to idle, then round-robin resumes past the drained grant
        apply(8'h00, 5'h00, 1'b0, 1'b1);
        apply(8'h00, 5'h00, 1'b0, 1'b1);
        apply(8'h24, 5'h05, 1'b1, 1'b0);
        settle();
        check("drain_y2", int'(y0), 2);
        apply(8'h00, 5'h00, 1'b1, 1'b1);
        settle();
        check("drain_idle", int'(v0), 0);
        apply(8'h00, 5'h00, 1'b1, 1'b0);
        apply(8'h24, 5'h05, 1'b1, 1'b0);
        settle();
        check("drain_y5", int'(y0), 5);

        // hold under stall
        apply(8'h04, 5'h04, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            apply(8'h01, 5'h01, 1'b0, 1'b0);
        settle();
        check("stall_y2", int'(y0), 2);
        check("stall_g04", int'(g0), 8'h04);
        apply(8'h01, 5'h01, 1'b0, 1'b1);
        settle();
        check("stall_y0", int'(y0), 0);

        rand_run(1500);

        // asynchronous reset in the middle of a grant
        apply(8'h00, 5'h00, 1'b0, 1'b1);
        apply(8'h00, 5'h00, 1'b0, 1'b1);
        apply(8'h20, 5'h10, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        check("pre_rst_valid", int'(v0), 1);
        check("pre_rst_y5", int'(y0), 5);
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(v0), 0);
        check("async_rst_grant", int'(g0), 0);
        check("async_rst_gcnt", int'(c0), 0);
        check("async_rst_valid5", int'(v1), 0);
        check("async_rst_gcnt5", int'(c1), 0);
        req8 = '0;
        req5 = '0;
        ack = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++)
            apply(8'h00, 5'h00, 1'b0, 1'b1);

        rand_run(1000);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prio_encoder_arb.md
Name: prio_encoder_arb

Overview:
- Parametrised, registered successor to the 8:3 combinational priority encoder.
- Encodes an N-bit request vector into a W-bit index plus a one-hot grant.
- Selectable priority mode: fixed (bit 0 highest) or round-robin.
- Holds each grant with a valid/ack handshake so a downstream consumer can stall. Sits between request sources and a shared resource.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, 3, index width; must equal ceil(log2(N)).
- CW, 8, width of the grant counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i  input  N  request vector; bit k set means requester k wants service.
- mode  input  1  0 = fixed priority, lowest index wins; 1 = round-robin.
- ack  input  1  consumer accepts the current grant; meaningful only while valid = 1.
- y  output  W  index of the granted requester.
- grant  output  N  one-hot copy of y; all zeros when valid = 0.
- valid  output  1  y/grant hold a live grant.
- gcnt  output  CW  number of acknowledged grants, wraps modulo 2^CW.

Behaviour:
- Reset is asynchronous: y = 0, grant = 0, valid = 0, gcnt = 0, round-robin pointer ptr = 0, state = IDLE. Reset asserted mid-grant drops valid immediately, with no ack required.
- All outputs are registered. No combinational path runs from i, mode or ack to any output.
- Winner selection (combinational, internal):
  - Fixed mode: lowest set index of i.
  - Round-robin mode: first set index searching upward from ptr, wrapping N-1 -> 0.
  - i == 0 means no winner.
- State IDLE:
  - Winner exists: next edge loads y/grant, sets valid = 1, goes to GRANT. Latency is 1 cycle from i sampled nonzero to valid = 1.
  - No winner: stay in IDLE, outputs unchanged (valid = 0, grant = 0). y keeps its last value and is don't-care while valid = 0.
- State GRANT, ack = 0:
  - y, grant and valid hold stable.
  - Changes on i, including deassertion of the granted bit, are ignored.
  - A mode change is ignored until the next arbitration.
- State GRANT, ack = 1, on the edge:
  - gcnt increments.
  - ptr becomes (y + 1) mod N. This update happens in both modes, so a switch to round-robin resumes fairly.
  - Re-arbitrate on the current i and mode, with ptr taken as the updated value, i.e. (y + 1) mod N.
  - Winner exists: load the new y/grant, keep valid = 1, stay in GRANT. Back-to-back grants are possible with no bubble.
  - No winner: valid = 0, grant = 0, go to IDLE.
- ack while valid = 0 is ignored: no count, no pointer change.
- ptr wrap: y = N-1 acknowledged gives ptr = 0.
- gcnt wraps from 2^CW-1 to 0 silently.
- Single requester held high in round-robin mode is granted every cycle while ack = 1.
- Non-power-of-two N: indices >= N never appear on y.
- Unknown output: when valid = 0, grant is forced to zero. The design never drives x.

Test Plan:
- Reset/idle: assert rst mid-grant with y = 5, valid = 1 -> valid = 0, grant = 0, gcnt = 0 immediately, without waiting for a clock edge. Then i = 0 for 5 cycles -> valid stays 0.
- Fixed priority: mode = 0, i = 8'b1010_1000, ack = 1 each cycle -> grants y = 3, 3, 3… (bit 3 always wins). Then i = 8'b1000_0000 -> y = 7, grant = 8'h80, 1 cycle after i changes.
- Round-robin rotation: mode = 1, i = 8'hFF, ack held 1 -> y sequence 0, 1, 2 … 7, 0 (wrap). gcnt = 9 after 9 acks.
- Hold under stall: grant y = 2 issued, ack = 0 for 4 cycles while i changes to 8'h01 -> y = 2, grant = 8'h04 held. On ack, fixed mode -> y = 0 next cycle.
- Drain to idle: mode = 1, i = 8'h24, y = 2, i drops to 0 in the same cycle as ack = 1 -> next cycle valid = 0, state IDLE. Later i = 8'h24 -> y = 5 (ptr = 3).
- Parameter sweep: N = 5, W = 3, CW = 2, round-robin with i = 5'b11111 -> y cycles 0..4 and never shows 5–7. gcnt wraps 3 -> 0 on the 4th ack.
